// File: rtl/gate_test_seq.sv
// Sequencer for testing 2-input logic gates: walks the four input vectors,
// samples synchronised gate outputs after a settle time, and reports pass/fail per gate.
module gate_test_seq #(
  parameter int unsigned SETTLE_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] tt,
  input  logic [2:0] num_gates,
  output logic [5:0] ic_a,
  output logic [5:0] ic_b,
  input  logic [5:0] ic_y,
  output logic       busy,
  output logic [5:0] pass,
  output logic [5:0] fail,
  output logic       icg
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE} state_t;

  localparam logic [7:0] CNT_LAST = 8'(SETTLE_CYCLES - 1);

  state_t     state_q;
  logic [1:0] vec_q;
  logic [7:0] cnt_q;
  logic [3:0] ttCap_q;
  logic [5:0] en_q;
  logic [5:0] failAcc_q;
  logic [5:0] yMeta_q;
  logic [5:0] ySync_q;
  logic [5:0] icA_q;
  logic [5:0] icB_q;
  logic       busy_q;
  logic [5:0] pass_q;
  logic [5:0] fail_q;
  logic       icg_q;

  logic [2:0] numClamped;
  logic [5:0] en_d;
  logic [5:0] failAcc_d;
  logic [1:0] vec_d;

  // Requests above six gates collapse to six; enable the lowest numClamped gates.
  always_comb begin
    numClamped = (num_gates > 3'd6) ? 3'd6 : num_gates;
    en_d = '0;
    for (int i = 0; i < 6; i++) begin
      en_d[i] = (3'(i) < numClamped);
    end
  end

  assign failAcc_d = failAcc_q | (en_q & (ySync_q ^ {6{ttCap_q[vec_q]}}));
  assign vec_d     = vec_q + 2'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      vec_q     <= '0;
      cnt_q     <= '0;
      ttCap_q   <= '0;
      en_q      <= '0;
      failAcc_q <= '0;
      yMeta_q   <= '0;
      ySync_q   <= '0;
      icA_q     <= '0;
      icB_q     <= '0;
      busy_q    <= 1'b0;
      pass_q    <= '0;
      fail_q    <= '0;
      icg_q     <= 1'b0;
    end else begin
      yMeta_q <= ic_y;
      ySync_q <= yMeta_q;
      if (abort) begin
        state_q <= IDLE;
        vec_q   <= '0;
        cnt_q   <= '0;
        icA_q   <= '0;
        icB_q   <= '0;
        busy_q  <= 1'b0;
        pass_q  <= '0;
        fail_q  <= '0;
        icg_q   <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              ttCap_q   <= tt;
              en_q      <= en_d;
              failAcc_q <= '0;
              vec_q     <= '0;
              cnt_q     <= '0;
              icA_q     <= '0;
              icB_q     <= '0;
              pass_q    <= '0;
              fail_q    <= '0;
              icg_q     <= 1'b0;
              busy_q    <= 1'b1;
              state_q   <= SETTLE;
            end
          end
          SETTLE: begin
            cnt_q <= cnt_q + 8'd1;
            if (cnt_q == CNT_LAST) begin
              state_q <= SAMPLE;
            end
          end
          SAMPLE: begin
            failAcc_q <= failAcc_d;
            if (vec_q != 2'd3) begin
              vec_q   <= vec_d;
              cnt_q   <= '0;
              icA_q   <= {6{vec_d[1]}};
              icB_q   <= {6{vec_d[0]}};
              state_q <= SETTLE;
            end else begin
              // Final vector: results use the accumulator including this sample.
              pass_q  <= en_q & ~failAcc_d;
              fail_q  <= en_q & failAcc_d;
              icg_q   <= 1'b1;
              busy_q  <= 1'b0;
              vec_q   <= '0;
              cnt_q   <= '0;
              icA_q   <= '0;
              icB_q   <= '0;
              state_q <= IDLE;
            end
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            icA_q   <= '0;
            icB_q   <= '0;
          end
        endcase
      end
    end
  end

  assign ic_a = icA_q;
  assign ic_b = icB_q;
  assign busy = busy_q;
  assign pass = pass_q;
  assign fail = fail_q;
  assign icg  = icg_q;

endmodule

// File: tb/tb_gate_test_seq.sv
// Directed bench for gate_test_seq: table of gate models and faults with
// hand-computed results, plus sequences for sequencing, abort, busy-start and reset.
module tb_gate_test_seq;

  localparam int GATE_AND  = 0;
  localparam int GATE_NAND = 1;
  localparam int GATE_OR   = 2;
  localparam int GATE_XOR  = 3;
  localparam int GATE_NOR  = 4;

  typedef struct {
    string      name;
    logic [2:0] numGates;
    logic [3:0] tt;
    int         gateFn;
    logic [5:0] stuck1;
    logic [5:0] stuck0;
    logic [5:0] expPass;
    logic [5:0] expFail;
  } vec_t;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic       abort;
  logic [3:0] tt;
  logic [2:0] num_gates;
  logic [5:0] ic_a;
  logic [5:0] ic_b;
  logic [5:0] ic_y;
  logic       busy;
  logic [5:0] pass;
  logic [5:0] fail;
  logic       icg;

  int         gateFn;
  logic [5:0] stuck1;
  logic [5:0] stuck0;
  int         tests;
  int         failures;
  vec_t       vecs[8];

  gate_test_seq #(.SETTLE_CYCLES(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .tt(tt), .num_gates(num_gates), .ic_a(ic_a), .ic_b(ic_b), .ic_y(ic_y),
    .busy(busy), .pass(pass), .fail(fail), .icg(icg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic gateOut(input int fn, input logic a, input logic b);
    case (fn)
      GATE_AND:  return a & b;
      GATE_NAND: return ~(a & b);
      GATE_OR:   return a | b;
      GATE_XOR:  return a ^ b;
      default:   return ~(a | b);
    endcase
  endfunction

  // Device under test model: six identical gates with optional stuck-at faults.
  always_comb begin
    ic_y = '0;
    for (int i = 0; i < 6; i++) begin
      if (stuck1[i])      ic_y[i] = 1'b1;
      else if (stuck0[i]) ic_y[i] = 1'b0;
      else                ic_y[i] = gateOut(gateFn, ic_a[i], ic_b[i]);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pulseStart();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic pulseAbort();
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
  endtask

  task automatic waitEdges(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  // Runs one table entry; tt/num_gates are scrambled after start to prove capture.
  task automatic applyStimulus(input vec_t v);
    int lat;
    tt        = v.tt;
    num_gates = v.numGates;
    gateFn    = v.gateFn;
    stuck1    = v.stuck1;
    stuck0    = v.stuck0;
    pulseStart();
    checkOutput({v.name, " busyAfterStart"}, 32'(busy), 32'd1);
    tt        = ~v.tt;
    num_gates = ~v.numGates;
    lat = 101;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      #1;
      if (icg) begin
        lat = k;
        break;
      end
    end
    checkOutput({v.name, " latency"}, 32'(lat), 32'd36);
    checkOutput({v.name, " pass"}, 32'(pass), 32'(v.expPass));
    checkOutput({v.name, " fail"}, 32'(fail), 32'(v.expFail));
    checkOutput({v.name, " busyAtDone"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int errs;
    int lat;
    logic [1:0] p;
    tests = 0;
    failures = 0;
    reset_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    tt = 4'b1000;
    num_gates = 3'd6;
    gateFn = GATE_AND;
    stuck1 = '0;
    stuck0 = '0;

    vecs[0] = '{"and4",      3'd4, 4'b1000, GATE_AND,  6'b000000, 6'b000000, 6'b001111, 6'b000000};
    vecs[1] = '{"nandStuck", 3'd6, 4'b0111, GATE_NAND, 6'b000100, 6'b000000, 6'b111011, 6'b000100};
    vecs[2] = '{"and7as6",   3'd7, 4'b1000, GATE_AND,  6'b000000, 6'b000000, 6'b111111, 6'b000000};
    vecs[3] = '{"zeroGates", 3'd0, 4'b1000, GATE_OR,   6'b000000, 6'b000000, 6'b000000, 6'b000000};
    vecs[4] = '{"xorStuck0", 3'd6, 4'b0110, GATE_XOR,  6'b000000, 6'b100001, 6'b011110, 6'b100001};
    vecs[5] = '{"orDisFlt",  3'd3, 4'b1110, GATE_OR,   6'b000000, 6'b010000, 6'b000111, 6'b000000};
    vecs[6] = '{"wrongTt",   3'd5, 4'b1000, GATE_OR,   6'b000000, 6'b000000, 6'b000000, 6'b011111};
    vecs[7] = '{"norStuck1", 3'd2, 4'b0001, GATE_NOR,  6'b000010, 6'b000000, 6'b000001, 6'b000010};

    #12;
    checkOutput("resetBusy", 32'(busy), 32'd0);
    checkOutput("resetIcg", 32'(icg), 32'd0);
    checkOutput("resetPassFail", 32'({pass, fail}), 32'd0);
    checkOutput("resetIc", 32'({ic_a, ic_b}), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

    // Vector sequencing: 00,01,10,11 each for 9 cycles, then back to 0 in IDLE.
    tt = 4'b1000;
    num_gates = 3'd6;
    gateFn = GATE_AND;
    stuck1 = '0;
    stuck0 = '0;
    pulseStart();
    errs = 0;
    for (int k = 0; k <= 36; k++) begin
      @(negedge clk);
      p = (k < 36) ? 2'(k / 9) : 2'd0;
      if (ic_a !== {6{p[1]}} || ic_b !== {6{p[0]}}) errs++;
    end
    checkOutput("vectorSequence", 32'(errs), 32'd0);
    checkOutput("seqIcg", 32'(icg), 32'd1);
    checkOutput("seqPass", 32'(pass), 32'h3f);

    pulseAbort();
    checkOutput("idleAbortPass", 32'(pass), 32'd0);
    checkOutput("idleAbortIcg", 32'(icg), 32'd0);

    // Start while busy must not restart the run.
    pulseStart();
    waitEdges(10);
    pulseStart();
    lat = 11;
    while (!icg && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput("busyStartLatency", 32'(lat), 32'd36);

    // Abort while vec=2.
    pulseStart();
    waitEdges(20);
    checkOutput("preAbortIcA", 32'(ic_a), 32'h3f);
    pulseAbort();
    checkOutput("abortBusy", 32'(busy), 32'd0);
    checkOutput("abortIcg", 32'(icg), 32'd0);
    checkOutput("abortPassFail", 32'({pass, fail}), 32'd0);
    checkOutput("abortIc", 32'({ic_a, ic_b}), 32'd0);
    applyStimulus(vecs[1]);

    // Asynchronous reset mid-run, then no activity without a new start.
    pulseStart();
    waitEdges(20);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstIc", 32'({ic_a, ic_b}), 32'd0);
    checkOutput("rstPassFailIcg", 32'({pass, fail, icg}), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    waitEdges(50);
    checkOutput("postRstIdle", 32'({busy, icg, pass, fail, ic_a, ic_b}), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/gate_test_seq.md
GATE_TEST_SEQ -- requirements
Module: gate_test_seq

Interface
REQ-001 Parameter SETTLE_CYCLES, default 8: cycles each input vector is held before the gate outputs are sampled; legal range 3..255.
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  one-cycle request to begin a test run; acted on only in IDLE.
REQ-005 abort  input  1  synchronous cancel of a run in progress.
REQ-006 tt  input  4  expected gate output per vector; tt[v] applies to vector v.
REQ-007 num_gates  input  3  number of gates under test, 0..6; values 7 and above are treated as 6.
REQ-008 ic_a  output  6  A-input drive to gates 1..6.
REQ-009 ic_b  output  6  B-input drive to gates 1..6.
REQ-010 ic_y  input  6  gate outputs from the device under test; asynchronous to clk.
REQ-011 busy  output  1  high while a run is in progress.
REQ-012 pass  output  6  per-gate pass flags; bit i maps to downstream pass(i+1).
REQ-013 fail  output  6  per-gate fail flags; bit i maps to downstream fail(i+1).
REQ-014 icg  output  1  results valid; level signal.

Function
REQ-015 States SHALL be IDLE, SETTLE and SAMPLE, with a 2-bit vector index vec and an 8-bit settle counter cnt.
REQ-016 In IDLE with start=1 and abort=0: capture tt and the clamped num_gates; clear pass, fail, icg and the fail accumulator; set vec=0 and cnt=0; go to SETTLE.
REQ-017 Gate enable mask: en[i]=1 for every i < clamped num_gates; all other bits are 0.
REQ-018 While busy, all six gates are driven identically: ic_a = {6{vec[1]}} and ic_b = {6{vec[0]}}; in IDLE, ic_a = ic_b = 0.
REQ-019 SETTLE: cnt increments every cycle; when cnt == SETTLE_CYCLES-1 the block goes to SAMPLE. The state lasts exactly SETTLE_CYCLES cycles.
REQ-020 ic_y passes through a 2-flop synchronizer (y_s) that runs every cycle; only y_s is compared.
REQ-021 SAMPLE (one cycle): fail_acc |= en & (y_s ^ {6{tt_cap[vec]}}).
REQ-022 SAMPLE with vec<3: vec increments, cnt clears, next state is SETTLE.
REQ-023 SAMPLE with vec==3: on the same edge, pass <= en & ~fail_acc_next and fail <= en & fail_acc_next; icg <= 1; state returns to IDLE.
REQ-024 Latency: icg rises exactly 4*(SETTLE_CYCLES+1) rising edges after the edge that sampled start (36 when SETTLE_CYCLES=8).
REQ-025 pass, fail and icg hold their values until the next accepted start or abort.
REQ-026 Disabled gates never set pass or fail. Invariant: (pass & fail) == 0.
REQ-027 busy = 1 in SETTLE and SAMPLE, 0 in IDLE.
REQ-028 start while busy is ignored.
REQ-029 abort (any state) takes priority over start: next state IDLE; pass, fail and icg are cleared; ic_a and ic_b return to 0.
REQ-030 num_gates=0 completes a full run and ends with pass=0, fail=0, icg=1.
REQ-031 tt and num_gates changes during a run have no effect; the captured values are used.

Reset
REQ-032 While reset_n=0: state IDLE; vec, cnt, fail_acc, y_s, ic_a, ic_b, busy, pass, fail and icg all read 0, applied asynchronously.
REQ-033 Reset asserted mid-run discards the run; after release, no outputs change until a new start.

Verification
REQ-034 Happy path: SETTLE_CYCLES=8, num_gates=4, tt=4'b1000 (AND), DUT model = ideal AND on all 6 gates -> after 36 edges icg=1, pass=6'b001111, fail=0; busy low on the same edge.
REQ-035 Single fault: num_gates=6, tt=4'b0111 (NAND), gate 3 stuck-at-1 -> pass=6'b111011, fail=6'b000100.
REQ-036 Vector sequencing: monitor ic_a/ic_b -> pairs 00, 01, 10, 11, each held 9 cycles; both return to 0 in IDLE.
REQ-037 Abort at vec=2 -> next cycle busy=0, icg=0, pass=fail=0; a following start runs a full 36-cycle test.
REQ-038 Boundary cases: num_gates=7 behaves as 6; num_gates=0 gives icg=1 with pass=fail=0; start pulsed while busy causes no restart; reset_n low at cycle 20 clears all outputs asynchronously.
